// File: rtl/avalon_counter_pkg.sv
// Register map, config bit layout and byte-lane helper shared by the counter array.
package avalon_counter_pkg;

    localparam logic [1:0] REG_COUNT   = 2'd0;
    localparam logic [1:0] REG_CONFIG  = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_COMPARE = 2'd3;

    localparam logic [1:0] GLB_IRQ  = 2'd0;
    localparam logic [1:0] GLB_INFO = 2'd1;

    localparam int CFG_EN      = 0;
    localparam int CFG_DIR     = 1;
    localparam int CFG_INTEN   = 2;
    localparam int CFG_ONESHOT = 3;

    localparam int STS_FLAG    = 0;
    localparam int STS_RUNNING = 1;

    typedef struct packed {
        logic oneshot;
        logic inten;
        logic dir;
        logic en;
    } cfg_t;

    // Expands a 4-bit byte enable into a 32-bit bit mask.
    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            m[i*8 +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/counter_channel.sv
// One counter/timer channel: counter, config, compare and sticky match flag.
// Host writes are merged under a bit mask so partial-lane writes share one path.
module counter_channel
    import avalon_counter_pkg::*;
#(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we_count_i,
    input  logic                   we_cfg_i,
    input  logic                   we_status_i,
    input  logic                   we_compare_i,
    input  logic [COUNT_WIDTH-1:0] wr_data_i,
    input  logic [COUNT_WIDTH-1:0] wr_mask_i,
    output logic [COUNT_WIDTH-1:0] count_o,
    output cfg_t                   cfg_o,
    output logic [COUNT_WIDTH-1:0] compare_o,
    output logic                   flag_o
);

    localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [COUNT_WIDTH-1:0] compare_q, compare_d;
    cfg_t                   cfg_q, cfg_d;
    logic                   flag_q, flag_d;
    logic                   event_hit;

    function automatic logic [COUNT_WIDTH-1:0] merge(
        input logic [COUNT_WIDTH-1:0] old_val,
        input logic [COUNT_WIDTH-1:0] new_val,
        input logic [COUNT_WIDTH-1:0] mask
    );
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    always_comb begin
        count_d   = count_q;
        compare_d = compare_q;
        cfg_d     = cfg_q;
        flag_d    = flag_q;
        event_hit = 1'b0;

        if (cfg_q.en) begin
            if (cfg_q.dir) begin
                if (count_q == compare_q) begin
                    count_d   = '0;
                    event_hit = 1'b1;
                end else begin
                    count_d = count_q + ONE;
                end
            end else if (count_q == '0) begin
                count_d   = compare_q;
                event_hit = 1'b1;
            end else begin
                count_d = count_q - ONE;
            end
        end

        if (event_hit && cfg_q.oneshot) begin
            cfg_d.en = 1'b0;
        end

        // Host writes come last so they override the count update and one-shot clear.
        if (we_count_i) begin
            count_d = merge(count_q, wr_data_i, wr_mask_i);
        end
        if (we_cfg_i) begin
            cfg_d = cfg_t'((cfg_q & ~wr_mask_i[3:0]) | (wr_data_i[3:0] & wr_mask_i[3:0]));
        end
        if (we_compare_i) begin
            compare_d = merge(compare_q, wr_data_i, wr_mask_i);
        end

        if (we_status_i && wr_data_i[STS_FLAG] && wr_mask_i[STS_FLAG]) begin
            flag_d = 1'b0;
        end
        if (event_hit) begin
            flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            compare_q <= '1;
            cfg_q     <= '0;
            flag_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            cfg_q     <= cfg_d;
            flag_q    <= flag_d;
        end
    end

    assign count_o   = count_q;
    assign cfg_o     = cfg_q;
    assign compare_o = compare_q;
    assign flag_o    = flag_q;

endmodule

// File: rtl/avalon_counter_array.sv
// Avalon-MM array of CHANNELS counter/timer channels plus a global status page.
// Optional AVALON_COUNTER_BYTEENABLE_EN adds a byteenable port for per-lane writes.
module avalon_counter_array
    import avalon_counter_pkg::*;
#(
    parameter int   CHANNELS     = 4,
    parameter int   COUNT_WIDTH  = 32,
    parameter int   READ_LATENCY = 1,
    localparam int  ADDR_WIDTH   = $clog2(CHANNELS + 1) + 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           data_in,
`ifdef AVALON_COUNTER_BYTEENABLE_EN
    input  logic [3:0]            byteenable,
`endif
    output logic                  read_valid,
    output logic [31:0]           data_out,
    output logic                  irq
);

    localparam int             PW            = ADDR_WIDTH - 2;
    localparam logic [PW-1:0]  GLB_PAGE      = PW'(CHANNELS);
    localparam logic [7:0]     INFO_CHANNELS = 8'(CHANNELS);
    localparam logic [7:0]     INFO_WIDTH    = 8'(COUNT_WIDTH);

    logic [PW-1:0]          page;
    logic [1:0]             reg_sel;
    logic [31:0]            wr_mask;
    logic [31:0]            rd_data;
    logic [CHANNELS-1:0]    irq_status;

    logic [COUNT_WIDTH-1:0] ch_count   [CHANNELS];
    logic [COUNT_WIDTH-1:0] ch_compare [CHANNELS];
    cfg_t                   ch_cfg     [CHANNELS];
    logic                   ch_flag    [CHANNELS];

    assign page    = address[ADDR_WIDTH-1:2];
    assign reg_sel = address[1:0];

`ifdef AVALON_COUNTER_BYTEENABLE_EN
    assign wr_mask = be_to_mask(byteenable);
`else
    assign wr_mask = '1;
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic hit;
        assign hit = write && (page == PW'(c));

        counter_channel #(
            .COUNT_WIDTH (COUNT_WIDTH)
        ) u_channel (
            .clk          (clk),
            .reset        (reset),
            .we_count_i   (hit && (reg_sel == REG_COUNT)),
            .we_cfg_i     (hit && (reg_sel == REG_CONFIG)),
            .we_status_i  (hit && (reg_sel == REG_STATUS)),
            .we_compare_i (hit && (reg_sel == REG_COMPARE)),
            .wr_data_i    (data_in[COUNT_WIDTH-1:0]),
            .wr_mask_i    (wr_mask[COUNT_WIDTH-1:0]),
            .count_o      (ch_count[c]),
            .cfg_o        (ch_cfg[c]),
            .compare_o    (ch_compare[c]),
            .flag_o       (ch_flag[c])
        );

        assign irq_status[c] = ch_flag[c] & ch_cfg[c].inten;
    end

    // Read data is built from registered state only, so a same-cycle write is not visible.
    always_comb begin
        rd_data = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (page == PW'(c)) begin
                case (reg_sel)
                    REG_COUNT:  rd_data[COUNT_WIDTH-1:0] = ch_count[c];
                    REG_CONFIG: rd_data[CFG_ONESHOT:CFG_EN] = ch_cfg[c];
                    REG_STATUS: begin
                        rd_data[STS_FLAG]    = ch_flag[c];
                        rd_data[STS_RUNNING] = ch_cfg[c].en;
                    end
                    default:    rd_data[COUNT_WIDTH-1:0] = ch_compare[c];
                endcase
            end
        end
        if (page == GLB_PAGE) begin
            case (reg_sel)
                GLB_IRQ:  rd_data[CHANNELS-1:0] = irq_status;
                GLB_INFO: rd_data[15:0] = {INFO_WIDTH, INFO_CHANNELS};
                default:  rd_data = '0;
            endcase
        end
    end

    logic        rv1_q;
    logic [31:0] rd1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rv1_q <= 1'b0;
            rd1_q <= '0;
        end else begin
            rv1_q <= read;
            if (read) begin
                rd1_q <= rd_data;
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic        rv2_q;
        logic [31:0] rd2_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                rv2_q <= 1'b0;
                rd2_q <= '0;
            end else begin
                rv2_q <= rv1_q;
                if (rv1_q) begin
                    rd2_q <= rd1_q;
                end
            end
        end

        assign read_valid = rv2_q;
        assign data_out   = rd2_q;
    end else begin : g_lat1
        assign read_valid = rv1_q;
        assign data_out   = rd1_q;
    end

    assign irq = |irq_status;

endmodule

// File: tb/tb_avalon_counter_array.sv
// Bench for avalon_counter_array: two instances (read latency 1 and 2) share the bus and
// are compared every cycle against a behavioural model, plus directed literal checks.
module tb_avalon_counter_array;

    localparam int NCH = 4;

    logic        clk;
    logic        reset;
    logic        read;
    logic        write;
    logic [4:0]  address;
    logic [31:0] data_in;
    logic        rv1, rv2, irq1, irq2;
    logic [31:0] do1, do2;
`ifdef AVALON_COUNTER_BYTEENABLE_EN
    logic [3:0]  byteenable = 4'hF;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    avalon_counter_array #(.CHANNELS(NCH), .COUNT_WIDTH(32), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .read(read), .write(write),
        .address(address), .data_in(data_in),
`ifdef AVALON_COUNTER_BYTEENABLE_EN
        .byteenable(byteenable),
`endif
        .read_valid(rv1), .data_out(do1), .irq(irq1)
    );

    avalon_counter_array #(.CHANNELS(NCH), .COUNT_WIDTH(32), .READ_LATENCY(2)) u_dut2 (
        .clk(clk), .reset(reset), .read(read), .write(write),
        .address(address), .data_in(data_in),
`ifdef AVALON_COUNTER_BYTEENABLE_EN
        .byteenable(byteenable),
`endif
        .read_valid(rv2), .data_out(do2), .irq(irq2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int due; logic [31:0] data; } rd_t;

    logic [31:0] m_cnt  [NCH];
    logic [31:0] m_cmp  [NCH];
    logic [3:0]  m_cfg  [NCH];   // {oneshot, inten, dir, en}
    logic        m_flag [NCH];
    logic        m_irq, m_v1, m_v2;
    logic [31:0] m_d1, m_d2;
    rd_t         q1[$], q2[$];
    int          ec = 0;
    bit          model_ok = 0;

    function automatic logic [31:0] m_read(input logic [4:0] a);
        int pg, r;
        logic [31:0] v;
        pg = int'(a[4:2]);
        r  = int'(a[1:0]);
        v  = 32'd0;
        if (pg < NCH) begin
            case (r)
                0: v = m_cnt[pg];
                1: v = {28'd0, m_cfg[pg]};
                2: v = {30'd0, m_cfg[pg][0], m_flag[pg]};
                default: v = m_cmp[pg];
            endcase
        end else if (pg == NCH) begin
            if (r == 0) begin
                for (int c = 0; c < NCH; c++) v[c] = m_flag[c] & m_cfg[c][2];
            end else if (r == 1) begin
                v = 32'h0000_2004;
            end
        end
        return v;
    endfunction

    always @(posedge clk) begin
        ec++;
        if (reset) begin
            model_ok = 1;
            for (int c = 0; c < NCH; c++) begin
                m_cnt[c] = 32'd0; m_cmp[c] = 32'hFFFF_FFFF; m_cfg[c] = 4'd0; m_flag[c] = 1'b0;
            end
            q1.delete(); q2.delete();
            m_v1 = 0; m_v2 = 0; m_d1 = 32'd0; m_d2 = 32'd0; m_irq = 0;
        end else if (model_ok) begin
            if (read) begin
                logic [31:0] rv;
                rv = m_read(address);
                q1.push_back('{ec, rv});
                q2.push_back('{ec + 1, rv});
            end
            for (int c = 0; c < NCH; c++) begin
                logic        ev, nflag;
                logic [31:0] nc, ncmp;
                logic [3:0]  ncfg;
                ev = 0; nc = m_cnt[c]; ncmp = m_cmp[c]; ncfg = m_cfg[c]; nflag = m_flag[c];
                if (m_cfg[c][0]) begin
                    if (m_cfg[c][1]) begin
                        if (m_cnt[c] == m_cmp[c]) begin nc = 32'd0; ev = 1; end
                        else nc = m_cnt[c] + 32'd1;
                    end else begin
                        if (m_cnt[c] == 32'd0) begin nc = m_cmp[c]; ev = 1; end
                        else nc = m_cnt[c] - 32'd1;
                    end
                    if (ev && m_cfg[c][3]) ncfg[0] = 1'b0;
                end
                if (write && int'(address[4:2]) == c) begin
                    case (address[1:0])
                        2'd0: nc = data_in;
                        2'd1: ncfg = data_in[3:0];
                        2'd2: if (data_in[0]) nflag = 1'b0;
                        default: ncmp = data_in;
                    endcase
                end
                if (ev) nflag = 1'b1;
                m_cnt[c] = nc; m_cmp[c] = ncmp; m_cfg[c] = ncfg; m_flag[c] = nflag;
            end
            m_v1 = 0;
            if (q1.size() != 0 && q1[0].due == ec) begin
                m_v1 = 1; m_d1 = q1[0].data; void'(q1.pop_front());
            end
            m_v2 = 0;
            if (q2.size() != 0 && q2[0].due == ec) begin
                m_v2 = 1; m_d2 = q2[0].data; void'(q2.pop_front());
            end
            m_irq = 0;
            for (int c = 0; c < NCH; c++) m_irq = m_irq | (m_flag[c] & m_cfg[c][2]);
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("rv_lat1",  32'(rv1),  32'(m_v1));
            chk("do_lat1",  do1,       m_d1);
            chk("irq_lat1", 32'(irq1), 32'(m_irq));
            chk("rv_lat2",  32'(rv2),  32'(m_v2));
            chk("do_lat2",  do2,       m_d2);
            chk("irq_lat2", 32'(irq2), 32'(m_irq));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        write = 1'b1; read = 1'b0; address = a; data_in = d;
        cyc();
        write = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
        read = 1'b1; write = 1'b0; address = a;
        cyc();
        read = 1'b0;
        chk(name, do1, exp);
        chk({name, "_valid"}, 32'(rv1), 32'd1);
    endtask

    initial begin
        logic [31:0] seq1 [5];
        logic [31:0] seq0 [5];
        seq1 = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
        seq0 = '{32'd2, 32'd1, 32'd0, 32'd5, 32'd5};

        reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; data_in = '0;
        #1;
        repeat (2) cyc();
        reset = 1'b0;

        chk("reset_rv",  32'(rv1),  32'd0);
        chk("reset_do",  do1,       32'd0);
        chk("reset_irq", 32'(irq1), 32'd0);
        for (int c = 0; c < NCH; c++) begin
            for (int r = 0; r < 4; r++) begin
                rd_chk("reset_reg", 5'(c * 4 + r), (r == 3) ? 32'hFFFF_FFFF : 32'd0);
            end
        end
        rd_chk("info", 5'd17, 32'h0000_2004);

        // ch1 up-count with compare 3
        wr(5'd7, 32'd3);
        wr(5'd5, 32'd7);
        for (int i = 0; i < 5; i++) begin
            read = 1'b1; address = 5'd4;
            cyc();
            chk("ch1_seq", do1, seq1[i]);
            if (i == 2) chk("ch1_irq_before", 32'(irq1), 32'd0);
            if (i == 3) chk("ch1_irq_after",  32'(irq1), 32'd1);
        end
        read = 1'b0;
        wr(5'd6, 32'd1);
        chk("ch1_w1c_irq", 32'(irq1), 32'd0);
        wr(5'd5, 32'd0);

        // ch0 down, one-shot
        wr(5'd0, 32'd2);
        wr(5'd3, 32'd5);
        wr(5'd1, 32'd13);
        for (int i = 0; i < 5; i++) begin
            read = 1'b1; address = 5'd0;
            cyc();
            chk("ch0_seq", do1, seq0[i]);
        end
        read = 1'b0;
        chk("ch0_irq", 32'(irq1), 32'd1);
        rd_chk("ch0_cfg", 5'd1, 32'd12);
        rd_chk("ch0_status", 5'd2, 32'd1);
        wr(5'd2, 32'd1);
        chk("ch0_w1c_irq", 32'(irq1), 32'd0);

        // counter write collides with count update
        wr(5'd11, 32'd1000);
        wr(5'd9, 32'd3);
        repeat (7) cyc();
        wr(5'd8, 32'd100);
        rd_chk("ch2_collide", 5'd8, 32'd100);

        // W1C collides with event
        wr(5'd15, 32'd0);
        wr(5'd13, 32'd3);
        cyc();
        wr(5'd14, 32'd1);
        rd_chk("ch3_w1c_vs_event", 5'd14, 32'd3);
        wr(5'd13, 32'd0);

        // latency-2 back-to-back reads
        wr(5'd4, 32'h55);
        read = 1'b1; address = 5'd0;
        cyc();
        address = 5'd4;
        cyc();
        chk("lat2_d0", do2, 32'd5);
        chk("lat2_v0", 32'(rv2), 32'd1);
        address = 5'd20;
        cyc();
        chk("lat2_d1", do2, 32'h55);
        chk("lat2_v1", 32'(rv2), 32'd1);
        read = 1'b0;
        cyc();
        chk("lat2_d2", do2, 32'd0);
        chk("lat2_v2", 32'(rv2), 32'd1);
        cyc();
        chk("lat2_idle", 32'(rv2), 32'd0);

        // reset mid-read with ch2 running
        read = 1'b1; address = 5'd8;
        cyc();
        reset = 1'b1;
        cyc();
        chk("rst_rv1", 32'(rv1), 32'd0);
        chk("rst_rv2", 32'(rv2), 32'd0);
        chk("rst_do1", do1, 32'd0);
        chk("rst_do2", do2, 32'd0);
        reset = 1'b0; read = 1'b0;
        rd_chk("rst_ch2_cnt", 5'd8, 32'd0);
        rd_chk("rst_ch2_cfg", 5'd9, 32'd0);
        rd_chk("rst_ch2_cmp", 5'd11, 32'hFFFF_FFFF);

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            reset   = ($urandom_range(0, 199) == 0);
            read    = 1'($urandom_range(0, 1));
            write   = ($urandom_range(0, 2) == 0);
            address = 5'($urandom_range(0, 31));
            case (address[1:0])
                2'd0: data_in = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 20));
                2'd1: data_in = 32'($urandom_range(0, 15));
                2'd2: data_in = 32'($urandom);
                default: data_in = 32'($urandom_range(0, 6));
            endcase
            cyc();
        end
        reset = 1'b0; read = 1'b0; write = 1'b0;
        repeat (4) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
